// File: rtl/rf_pulse_monitor_if.sv
// ---------------------------------------------------------------------------
// rf_pulse_monitor_if
//
// Signal bundle between the RF pulse-train monitor and its controller
// (the Arduino-facing glue, or a testbench).
//
// Parameters
//   CNT_W    : width of measured widths / readback data
//
// Signals
//   rf_in    : RF control line under test (asynchronous to clk)
//   arm      : level, high enables one measurement
//   rd_sel   : readback index (0=pulse1 1=gap1 2=pulse2 3=gap2 4=pulse3)
//   rd_width : measured width selected by rd_sel, 0 for indices 5..7
//   busy     : measurement in progress
//   done     : sequence complete or aborted by timeout
//   pass     : all five fields in tolerance (only meaningful with done)
//   err      : 0 none, 1..5 first failing field, 7 timeout
//
// Modports
//   master   : controller side, drives rf_in/arm/rd_sel
//   slave    : monitor side, drives the status and readback
// ---------------------------------------------------------------------------
interface rf_pulse_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             rf_in;
  logic             arm;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_width;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2:0]       err;

  modport master (
    output rf_in,
    output arm,
    output rd_sel,
    input  rd_width,
    input  busy,
    input  done,
    input  pass,
    input  err
  );

  modport slave (
    input  rf_in,
    input  arm,
    input  rd_sel,
    output rd_width,
    output busy,
    output done,
    output pass,
    output err
  );
endinterface

// File: rtl/rf_pulse_monitor.sv
// ---------------------------------------------------------------------------
// rf_pulse_monitor
//
// Receive-side checker for the interferometer RF pulse train
// (pi/2 - gap - pi - gap - pi/2). The RF line is synchronised, rise/fall
// events are detected, and the width of each of the five fields is measured
// in clk cycles, stored, and checked against its nominal value within
// +/- TOL_CYC. Status (busy/done/pass/err) and the stored widths are exposed
// for readback.
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : rf_pulse_monitor_if.slave (rf_in, arm, rd_sel in;
//            rd_width, busy, done, pass, err out)
//
// Optional feature
//   RF_MON_TIMEOUT_EN : when defined, any waiting/measuring state that dwells
//                       TIMEOUT_CYC cycles ends the run in DONE with err=7.
//                       When undefined, states wait indefinitely.
// ---------------------------------------------------------------------------
module rf_pulse_monitor #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PI_2_CYC    = 333,
  parameter int unsigned PI_CYC      = 666,
  parameter int unsigned GAP_CYC     = 66600,
  parameter int unsigned TOL_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_pulse_monitor_if.slave   bus
);

`ifdef RF_MON_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  // Tolerance arithmetic is done one bit wider so nom+TOL cannot overflow.
  localparam logic [CNT_W:0]   NomPi2     = (CNT_W+1)'(PI_2_CYC);
  localparam logic [CNT_W:0]   NomPi      = (CNT_W+1)'(PI_CYC);
  localparam logic [CNT_W:0]   NomGap     = (CNT_W+1)'(GAP_CYC);
  localparam logic [CNT_W:0]   Tol        = (CNT_W+1)'(TOL_CYC);
  localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYC);
  localparam logic [2:0]       ErrTimeout = 3'd7;

  typedef enum logic [3:0] {
    StIdle,
    StArmLow,
    StWaitP1,
    StHigh1,
    StGap1,
    StHigh2,
    StGap2,
    StHigh3,
    StDone
  } state_e;

  state_e state_q, state_d;

  // -------------------------------------------------------------------------
  // Input synchroniser and edge detection
  // -------------------------------------------------------------------------
  logic rf_meta_q, rf_s_q, rf_prev_q;
  logic rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_meta_q <= 1'b0;
      rf_s_q    <= 1'b0;
      rf_prev_q <= 1'b0;
    end else begin
      rf_meta_q <= bus.rf_in;
      rf_s_q    <= rf_meta_q;
      rf_prev_q <= rf_s_q;
    end
  end

  assign rise = rf_s_q & ~rf_prev_q;
  assign fall = ~rf_s_q & rf_prev_q;

  // -------------------------------------------------------------------------
  // Counters, fields and error code
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] dwell_q, dwell_d, dwell_inc;
  logic [CNT_W-1:0] field_q [5];
  logic [2:0]       err_q, err_d;
  logic             cap_en;
  logic [2:0]       cap_idx;
  logic             clr_fields;
  logic             in_run;
  logic             timeout_hit;

  // Saturating increments: a stuck line must never wrap back into tolerance.
  assign cnt_inc   = (cnt_q == '1)   ? cnt_q   : cnt_q + CNT_W'(1);
  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);

  // Dwell limit only exists when the timeout feature is compiled in.
  assign timeout_hit = TimeoutEn && (dwell_q >= TimeoutLim);

  assign in_run = (state_q == StArmLow) || (state_q == StWaitP1) ||
                  (state_q == StHigh1)  || (state_q == StGap1)   ||
                  (state_q == StHigh2)  || (state_q == StGap2)   ||
                  (state_q == StHigh3);

  function automatic logic [CNT_W:0] nom_of(input logic [2:0] idx);
    logic [CNT_W:0] nom;
    unique case (idx)
      3'd0, 3'd4: nom = NomPi2;
      3'd2:       nom = NomPi;
      default:    nom = NomGap;
    endcase
    return nom;
  endfunction

  // Lower bound clamps to zero when the nominal is smaller than the tolerance.
  function automatic logic in_tol(input logic [CNT_W-1:0] w, input logic [CNT_W:0] nom);
    logic [CNT_W:0] wx, lo, hi;
    wx = {1'b0, w};
    lo = (nom >= Tol) ? nom - Tol : '0;
    hi = nom + Tol;
    return (wx >= lo) && (wx <= hi);
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    dwell_d    = dwell_inc;
    err_d      = err_q;
    cap_en     = 1'b0;
    cap_idx    = 3'd0;
    clr_fields = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        dwell_d = '0;
        err_d   = '0;
        if (bus.arm) begin
          state_d    = StArmLow;
          clr_fields = 1'b1;
          dwell_d    = CNT_W'(1);
        end
      end
      // Discard a pulse already in progress when arm rose.
      StArmLow: begin
        cnt_d = '0;
        if (!rf_s_q) begin
          state_d = StWaitP1;
          dwell_d = CNT_W'(1);
        end
      end
      StWaitP1: begin
        cnt_d = '0;
        if (rise) begin
          state_d = StHigh1;
          cnt_d   = CNT_W'(1);
          dwell_d = CNT_W'(1);
        end
      end
      StHigh1: begin
        if (fall) begin
          state_d = StGap1;
          cap_en  = 1'b1;
          cap_idx = 3'd0;
        end
      end
      StGap1: begin
        if (rise) begin
          state_d = StHigh2;
          cap_en  = 1'b1;
          cap_idx = 3'd1;
        end
      end
      StHigh2: begin
        if (fall) begin
          state_d = StGap2;
          cap_en  = 1'b1;
          cap_idx = 3'd2;
        end
      end
      StGap2: begin
        if (rise) begin
          state_d = StHigh3;
          cap_en  = 1'b1;
          cap_idx = 3'd3;
        end
      end
      StHigh3: begin
        if (fall) begin
          state_d = StDone;
          cap_en  = 1'b1;
          cap_idx = 3'd4;
        end
      end
      StDone: begin
        cnt_d   = cnt_q;
        dwell_d = '0;
        if (!bus.arm) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A capture restarts both counters on the edge cycle.
    if (cap_en) begin
      cnt_d   = CNT_W'(1);
      dwell_d = CNT_W'(1);
      if ((err_q == 3'd0) && !in_tol(cnt_q, nom_of(cap_idx))) begin
        err_d = cap_idx + 3'd1;
      end
    end

    // Timeout only applies when no edge moved the FSM this cycle.
    if (in_run && (state_d == state_q) && timeout_hit) begin
      state_d = StDone;
      err_d   = ErrTimeout;
    end

    // Abort beats every other event; fields keep their last values.
    if (in_run && !bus.arm) begin
      state_d = StIdle;
      cap_en  = 1'b0;
      err_d   = '0;
      cnt_d   = '0;
      dwell_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dwell_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        field_q[i] <= '0;
      end
    end else if (clr_fields) begin
      for (int i = 0; i < 5; i++) begin
        field_q[i] <= '0;
      end
    end else if (cap_en) begin
      field_q[cap_idx] <= cnt_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.rd_width = '0;
    case (bus.rd_sel)
      3'd0:    bus.rd_width = field_q[0];
      3'd1:    bus.rd_width = field_q[1];
      3'd2:    bus.rd_width = field_q[2];
      3'd3:    bus.rd_width = field_q[3];
      3'd4:    bus.rd_width = field_q[4];
      default: bus.rd_width = '0;
    endcase
  end

  assign bus.busy = in_run;
  assign bus.done = (state_q == StDone);
  assign bus.pass = (state_q == StDone) && (err_q == 3'd0);
  assign bus.err  = err_q;

endmodule
